// File: rtl/i2c_slave_read.sv
// i2c_slave_read -- slave-side I2C receive engine.
// Samples SDA on every synchronized SCL rising edge and hands each bit to the
// controller as a one-cycle rd_ld strobe with data_o. Watches SDA while SCL
// is high: in bit 0 a transition is a START/STOP, in bits 1..7 a bus error.
// Any ending (normal or aborted) raises rd_finish, held until rd_en drops.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   rd_en                 1 = perform read, 0 = return to idle / clear status
//   is_byte               1 = 8 bits MSB first, 0 = single bit (latched on start)
//   rd_ld, data_o         received-bit strobe and bit value
//   rd_finish             transaction complete
//   get_start, get_stop   START / STOP seen during bit 0
//   bus_err               SDA moved while SCL high in bits 1..7
//   scl_i, sda_i          asynchronous bus lines
//
// Optional: define I2C_SLAVE_READ_GLITCH_FILTER_EN to add a 2-sample filter
// behind the synchronizers (one extra clock of latency, rejects 1-clk glitches).
module i2c_slave_read #(
  parameter int SYNC_STAGES = 2  // >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_en,
  input  logic is_byte,
  output logic rd_ld,
  output logic data_o,
  output logic rd_finish,
  output logic get_start,
  output logic get_stop,
  output logic bus_err,
  input  logic scl_i,
  input  logic sda_i
);

  typedef enum logic [1:0] {IDLE, WAIT_HIGH, HIGH, DONE} state_t;

  // synchronizers, preset to the idle-bus level
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end

  logic scl_s, sda_s;

`ifdef I2C_SLAVE_READ_GLITCH_FILTER_EN
  // hist holds the previous synchronized sample; the filtered value follows
  // the synchronizer only when the last two samples agree.
  logic scl_hist, sda_hist, scl_filt, sda_filt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      scl_hist <= scl_sync[SYNC_STAGES-1];
      sda_hist <= sda_sync[SYNC_STAGES-1];
      scl_filt <= scl_s;
      sda_filt <= sda_s;
    end
  end
  assign scl_s = (scl_sync[SYNC_STAGES-1] == scl_hist) ? scl_hist : scl_filt;
  assign sda_s = (sda_sync[SYNC_STAGES-1] == sda_hist) ? sda_hist : sda_filt;
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

  logic scl_prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scl_prev <= 1'b1;
    else        scl_prev <= scl_s;
  end

  logic scl_rise, scl_fall;
  assign scl_rise =  scl_s & ~scl_prev;
  assign scl_fall = ~scl_s &  scl_prev;

  // FSM + datapath registers
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       byte_q, byte_d;
  logic       bit_q, bit_d;
  logic       ld_q, ld_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= 1'b0;
      bit_q   <= 1'b0;
      ld_q    <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      ld_q    <= ld_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    ld_d    = 1'b0;
    start_d = start_q;
    stop_d  = stop_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        start_d = 1'b0;
        stop_d  = 1'b0;
        err_d   = 1'b0;
        if (rd_en) begin
          byte_d  = is_byte;
          cnt_d   = '0;
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // only a fresh rising edge samples; a high phase already in
        // progress when rd_en rose is skipped
        if (scl_rise) begin
          bit_d   = sda_s;
          ld_d    = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (scl_s) begin
          if (sda_s != bit_q) begin
            // captured 1 -> SDA fell = START; captured 0 -> SDA rose = STOP
            if (cnt_q == 3'd0) begin
              start_d = bit_q;
              stop_d  = ~bit_q;
            end else begin
              err_d = 1'b1;
            end
            state_d = DONE;
          end
        end else if (scl_fall) begin
          if (!byte_q || cnt_q == 3'd7) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            state_d = WAIT_HIGH;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    // dropping rd_en abandons whatever is in flight, without a finish
    if (!rd_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      ld_d    = 1'b0;
      start_d = 1'b0;
      stop_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  assign rd_ld     = ld_q;
  assign data_o    = ld_q & bit_q;
  assign rd_finish = (state_q == DONE);
  assign get_start = start_q;
  assign get_stop  = stop_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_i2c_slave_read.sv
// Randomized bench for i2c_slave_read. The reference is the bus-level rule
// set: bits go out MSB first; a read delivers every bit up to and including
// the one whose high phase carries an SDA transition; that transition in bit 0
// is START (1->0) or STOP (0->1), later it is a bus error.
module tb_i2c_slave_read;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rd_en = 1'b0, is_byte = 1'b0, scl_i = 1'b1, sda_i = 1'b1;
  logic rd_ld, data_o, rd_finish, get_start, get_stop, bus_err;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int t_rise, t_fall, t_tog, t_ld, t_fin, fin_cnt;
  logic fin_prev = 1'b0;
  bit rxq[$];

  always #5 clk = ~clk;

  i2c_slave_read #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .is_byte(is_byte),
    .rd_ld(rd_ld), .data_o(data_o), .rd_finish(rd_finish),
    .get_start(get_start), .get_stop(get_stop), .bus_err(bus_err),
    .scl_i(scl_i), .sda_i(sda_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    #1 cyc++;
    @(negedge clk);
    if (rd_ld) begin
      if (rxq.size() == 0) t_ld = cyc;
      rxq.push_back(data_o);
    end
    if (rd_finish && !fin_prev) begin
      fin_cnt++;
      t_fin = cyc;
    end
    fin_prev = rd_finish;
  endtask

  // one SCL period of 8 clocks; tog flips SDA one clock into the high phase
  task automatic send_bit(input bit b, input bit tog);
    scl_i = 1'b0;
    tick();
    sda_i = b;
    repeat (3) tick();
    scl_i = 1'b1;
    if (t_rise < 0) t_rise = cyc;
    tick();
    if (tog) begin
      sda_i = ~b;
      t_tog = cyc;
    end
    repeat (3) tick();
  endtask

  // err < 0: clean read; otherwise index of the bit whose high phase toggles
  task automatic do_read(input bit isb, input logic [7:0] v, input int err);
    int n, nexp, exp_val, got;
    logic [2:0] exp_flags;
    n = isb ? 8 : 1;
    nexp = (err < 0) ? n : err + 1;
    exp_val = 0;
    got = 0;
    rxq.delete();
    fin_cnt = 0;
    fin_prev = rd_finish;
    t_rise = -1;
    t_fin = -1000;
    t_ld = -1000;
    t_tog = 0;
    is_byte = isb;
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) send_bit(v[7-i], i == err);
    scl_i = 1'b0;
    t_fall = cyc;
    for (int k = 0; k < 40 && fin_cnt == 0; k++) tick();
    chk("finish_count", fin_cnt, 1);

    for (int i = 0; i < nexp; i++) exp_val = exp_val * 2 + int'(v[7-i]);
    foreach (rxq[i]) got = got * 2 + int'(rxq[i]);
    chk("nbits", rxq.size(), nexp);
    chk("data", got, exp_val);
    exp_flags = (err == 0) ? (v[7] ? 3'b100 : 3'b010) : (err > 0 ? 3'b001 : 3'b000);
    chk("flags", {get_start, get_stop, bus_err}, exp_flags);
    chk("ld_latency", t_ld - t_rise, 3);
    if (err < 0) chk("fin_latency", t_fin - t_fall, 3);
    else         chk("err_latency", (t_fin >= t_tog) && (t_fin - t_tog <= 4), 1);

    // extra bus activity while finished must be ignored
    sda_i = 1'b1;
    tick();
    scl_i = 1'b1;
    repeat (4) tick();
    chk("done_hold", {rd_finish, get_start, get_stop, bus_err}, {1'b1, exp_flags});
    chk("no_extra_ld", rxq.size(), nexp);

    rd_en = 1'b0;
    tick();
    chk("idle_clear", {rd_ld, data_o, rd_finish, get_start, get_stop, bus_err}, 6'd0);
    tick();
  endtask

  initial begin
    logic [7:0] v;
    repeat (3) tick();
    chk("reset_outs", {rd_ld, data_o, rd_finish, get_start, get_stop, bus_err}, 6'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    do_read(1'b0, 8'h80, -1);   // single bit, SDA=1
    do_read(1'b1, 8'hA5, -1);   // full byte
    do_read(1'b0, 8'h80, 0);    // 1 -> 0 while SCL high: START
    do_read(1'b0, 8'h00, 0);    // 0 -> 1 while SCL high: STOP
    do_read(1'b1, 8'h3C, 4);    // bus error in bit 4

    for (int r = 0; r < 32; r++) begin
      v = 8'($urandom);
      do_read(1'b0, v, -1);
      do_read(1'b1, v, -1);
      for (int k = 0; k < 8; k++) do_read(1'b1, v, k);
    end

    // reset in the middle of a byte
    rxq.delete();
    t_rise = -1;
    is_byte = 1'b1;
    rd_en = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    scl_i = 1'b0;
    tick();
    scl_i = 1'b1;
    repeat (3) tick();
    chk("pre_reset_ld", rxq.size(), 4);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {rd_ld, data_o, rd_finish, get_start, get_stop, bus_err}, 6'd0);
    rd_en = 1'b0;
    sda_i = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    do_read(1'b1, 8'h96, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_read.md
Name: i2c_slave_read

Overview:
Slave-side I2C receive engine. It samples SDA on each SCL rising edge and streams each received bit out as a one-cycle load strobe plus data bit. It also detects START/STOP conditions and bus errors (SDA toggling while SCL is high). It sits under the I2C slave controller, which enables it per bit or per byte and assembles the serial bits in its own shift register.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the scl_i/sda_i synchronizers (minimum 2).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rd_en  input  1  read enable; high = perform read, low = return to idle and clear status
is_byte  input  1  1 = read 8 bits MSB first, 0 = read 1 bit; captured when rd_en rises
rd_ld  output  1  one-cycle strobe: data_o holds a newly received bit
data_o  output  1  received bit, valid while rd_ld is high
rd_finish  output  1  read transaction complete (normal or aborted); held until rd_en goes low
get_start  output  1  START (SDA falls while SCL high) seen during bit 0; held with rd_finish
get_stop  output  1  STOP (SDA rises while SCL high) seen during bit 0; held with rd_finish
bus_err  output  1  SDA changed while SCL high during bits 1..7 of a byte; held with rd_finish
scl_i  input  1  I2C clock line, asynchronous
sda_i  input  1  I2C data line, asynchronous

Behaviour:
- Reset: all outputs 0, FSM in IDLE, bit counter 0, synchronizers preset to 1 (idle bus).
- scl_i and sda_i pass through SYNC_STAGES flops. All edge detection uses the synchronized values.
- Edge detection: scl_rise / scl_fall are single-cycle pulses derived from the current and previous synchronized SCL.
- IDLE: outputs 0. When rd_en=1, latch is_byte, set bit counter to 0, go to WAIT_HIGH.
- WAIT_HIGH: on scl_rise, capture synchronized SDA into a bit register and pulse rd_ld=1 for exactly one cycle with data_o = that bit. Go to HIGH.
- HIGH, while synchronized SCL=1:
  - If synchronized SDA differs from the captured bit, an SDA transition has occurred.
  - In bit index 0: falling transition sets get_start, rising transition sets get_stop.
  - In bit index 1..7: the transition sets bus_err.
  - In all these cases go to DONE immediately.
- HIGH, on scl_fall:
  - Last bit (index 0 in bit mode, index 7 in byte mode): go to DONE.
  - Otherwise: increment the counter and go to WAIT_HIGH.
- DONE: rd_finish=1. Status flags hold their value. Further SCL/SDA activity is ignored. Exit to IDLE (all outputs 0) when rd_en=0.
- rd_en falling in any state forces IDLE on the next clock and discards a partial byte. No rd_finish is produced in that case.
- rd_en rising while SCL is already high: wait for the next scl_rise. The current high phase is not sampled.
- Latency: rd_ld occurs SYNC_STAGES+1 clocks after scl_i rises. rd_finish occurs SYNC_STAGES+1 clocks after the final scl_i fall.
- An aborted read (start/stop/bus_err) still asserts rd_finish, so the controller never hangs. At most one of get_start/get_stop/bus_err is 1.
- Bits are delivered MSB first; the shift register lives in the consumer.

Optional Feature:
- Macro: I2C_SLAVE_READ_GLITCH_FILTER_EN.
- Defined: each synchronized line feeds a 2-sample filter. The filtered value changes only when two consecutive synchronized samples agree. This adds 1 clock to all latencies and rejects single-clock glitches.
- Undefined: synchronizer output is used directly.

Test Plan:
- Bit read, is_byte=0, SCL period 8 clk, SDA=1 stable while SCL high -> exactly one rd_ld with data_o=1; rd_finish=1 after SCL falls; all flags 0; rd_finish drops after rd_en=0.
- Byte read 0xA5, is_byte=1 -> 8 rd_ld pulses; shifter equals 8'hA5; rd_finish once after the 8th SCL fall; flags 0.
- Bit read, SDA=1 then toggled to 0 one clk after SCL rises -> get_start=1, rd_finish=1; bit data=0 then toggled to 1 -> get_stop=1.
- Byte 0x3C with SDA toggle in bit 4 high phase -> bus_err=1 and rd_finish=1 within 4 clks; remaining SCL pulses produce no rd_ld; cleared by rd_en=0.
- 32 random rounds: for each value, a bit read, a byte read, and 8 error positions -> zero data mismatches; no deadlock waiting for rd_finish.
- rst_n low mid-byte -> outputs 0 immediately; the next enabled read starts at bit 0.
